// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: combinational decode of the fetched word feeding a
// 2-entry skid buffer, so the upstream ready can be a flop without losing
// throughput.
//
// state | meaning
// EMPTY | no bundle held, out_valid_o low
// ONE   | head entry holds the oldest bundle
// TWO   | head and tail both hold bundles, input is stalled
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int PC_WIDTH  = 32,
    parameter int SUPPORT_M = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         in_instr_i,
    input  logic [PC_WIDTH-1:0] in_pc_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [PC_WIDTH-1:0] out_pc_o,
    output logic [6:0]          out_opcode_o,
    output logic [4:0]          out_rd_o,
    output logic [4:0]          out_rs1_o,
    output logic [4:0]          out_rs2_o,
    output logic [XLEN-1:0]     out_imm_o,
    output logic [3:0]          out_alu_op_o,
    output logic                out_muldiv_o,
    output logic                out_rd_we_o,
    output logic                out_mem_rd_o,
    output logic                out_mem_wr_o,
    output logic [1:0]          out_mem_size_o,
    output logic                out_mem_unsigned_o,
    output logic                out_branch_o,
    output logic                out_jump_o,
    output logic                out_illegal_o
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [XLEN-1:0]     imm;
        logic [3:0]          alu_op;
        logic                muldiv;
        logic                rd_we;
        logic                mem_rd;
        logic                mem_wr;
        logic [1:0]          mem_size;
        logic                mem_unsigned;
        logic                branch;
        logic                jump;
        logic                illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t  state;
    state_t  next_state;
    logic    ready_q;
    bundle_t dec;
    bundle_t head;
    bundle_t tail;
    logic    accept;
    logic    pop;
    logic    load_head;
    logic    load_tail;
    logic    head_from_tail;
    logic    illegal;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [6:0]  shift_hi;
    logic signed [31:0] imm32;

    assign opcode = in_instr_i[6:0];
    assign rd     = in_instr_i[11:7];
    assign funct3 = in_instr_i[14:12];
    assign rs1    = in_instr_i[19:15];
    assign rs2    = in_instr_i[24:20];
    assign funct7 = in_instr_i[31:25];

    assign imm_i = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
    assign imm_s = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
    assign imm_b = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                    in_instr_i[30:25], in_instr_i[11:8], 1'b0};
    assign imm_u = {in_instr_i[31:12], 12'b0};
    assign imm_j = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                    in_instr_i[20], in_instr_i[30:21], 1'b0};

    // RV64 shift amounts take one more bit, so only instr[31:26] must be clean.
    assign shift_hi = (XLEN == 64) ? {in_instr_i[31:26], 1'b0} : in_instr_i[31:25];

    // Decode the incoming word into a bundle; illegal words keep their fields
    // but lose every side effect.
    always_comb begin
        dec        = '0;
        imm32      = '0;
        illegal    = 1'b0;
        dec.pc     = in_pc_i;
        dec.opcode = opcode;
        if (in_instr_i[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_LOAD: begin
                    dec.rd           = rd;
                    dec.rs1          = rs1;
                    imm32            = imm_i;
                    dec.mem_rd       = 1'b1;
                    dec.mem_size     = funct3[1:0];
                    dec.mem_unsigned = funct3[2];
                    if (funct3 == 3'b111 ||
                        (XLEN == 32 && (funct3 == 3'b011 || funct3 == 3'b110)))
                        illegal = 1'b1;
                end
                OPC_MISC_MEM: begin
                    // FENCE is a NOP here: no registers, no side effects.
                end
                OPC_OP_IMM: begin
                    dec.rd     = rd;
                    dec.rs1    = rs1;
                    imm32      = imm_i;
                    dec.alu_op = {1'b0, funct3};
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        if (funct3 == 3'b101)
                            dec.alu_op[3] = in_instr_i[30];
                        if (!(shift_hi == 7'b0000000 ||
                              (funct3 == 3'b101 && shift_hi == 7'b0100000)))
                            illegal = 1'b1;
                    end
                end
                OPC_AUIPC, OPC_LUI: begin
                    dec.rd = rd;
                    imm32  = imm_u;
                end
                OPC_STORE: begin
                    dec.rs1      = rs1;
                    dec.rs2      = rs2;
                    imm32        = imm_s;
                    dec.mem_wr   = 1'b1;
                    dec.mem_size = funct3[1:0];
                    if (funct3[2] || (XLEN == 32 && funct3 == 3'b011))
                        illegal = 1'b1;
                end
                OPC_OP: begin
                    dec.rd     = rd;
                    dec.rs1    = rs1;
                    dec.rs2    = rs2;
                    dec.alu_op = {funct7[5], funct3};
                    if (funct7 == 7'b0000001 && SUPPORT_M != 0) begin
                        dec.muldiv = 1'b1;
                    end else if (funct7 == 7'b0100000) begin
                        if (funct3 != 3'b000 && funct3 != 3'b101)
                            illegal = 1'b1;
                    end else if (funct7 != 7'b0000000) begin
                        illegal = 1'b1;
                    end
                end
                OPC_BRANCH: begin
                    dec.rs1    = rs1;
                    dec.rs2    = rs2;
                    imm32      = imm_b;
                    dec.alu_op = {1'b0, funct3};
                    dec.branch = 1'b1;
                    if (funct3[2:1] == 2'b01)
                        illegal = 1'b1;
                end
                OPC_JALR: begin
                    dec.rd   = rd;
                    dec.rs1  = rs1;
                    imm32    = imm_i;
                    dec.jump = 1'b1;
                    if (funct3 != 3'b000)
                        illegal = 1'b1;
                end
                OPC_JAL: begin
                    dec.rd   = rd;
                    imm32    = imm_j;
                    dec.jump = 1'b1;
                end
                OPC_SYSTEM: begin
                    // Only ECALL and EBREAK are accepted, both as side-effect free.
                    if (in_instr_i != 32'h0000_0073 && in_instr_i != 32'h0010_0073)
                        illegal = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
        dec.imm     = XLEN'(imm32);
        dec.illegal = illegal;
        dec.rd_we   = (dec.rd != 5'd0) && !illegal;
        if (illegal) begin
            dec.mem_rd = 1'b0;
            dec.mem_wr = 1'b0;
            dec.branch = 1'b0;
            dec.jump   = 1'b0;
            dec.muldiv = 1'b0;
        end
    end

    assign accept = in_valid_i && ready_q;
    assign pop    = (state != EMPTY) && out_ready_i;

    // Skid-buffer next state and entry load controls; flush overrides all.
    always_comb begin
        next_state     = state;
        load_head      = 1'b0;
        load_tail      = 1'b0;
        head_from_tail = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    next_state = ONE;
                    load_head  = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    next_state = TWO;
                    load_tail  = 1'b1;
                end else if (pop) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    next_state     = ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
        if (flush_i) begin
            next_state     = EMPTY;
            load_head      = 1'b0;
            load_tail      = 1'b0;
            head_from_tail = 1'b0;
        end
    end

    // State register; ready is held low for as long as reset is asserted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != TWO);
        end
    end

    // Buffer entries; the tail only ever moves into the head, keeping FIFO order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head)
                head <= dec;
            else if (head_from_tail)
                head <= tail;
            if (load_tail)
                tail <= dec;
        end
    end

    assign in_ready_o         = ready_q;
    assign out_valid_o        = (state != EMPTY);
    assign out_pc_o           = head.pc;
    assign out_opcode_o       = head.opcode;
    assign out_rd_o           = head.rd;
    assign out_rs1_o          = head.rs1;
    assign out_rs2_o          = head.rs2;
    assign out_imm_o          = head.imm;
    assign out_alu_op_o       = head.alu_op;
    assign out_muldiv_o       = head.muldiv;
    assign out_rd_we_o        = head.rd_we;
    assign out_mem_rd_o       = head.mem_rd;
    assign out_mem_wr_o       = head.mem_wr;
    assign out_mem_size_o     = head.mem_size;
    assign out_mem_unsigned_o = head.mem_unsigned;
    assign out_branch_o       = head.branch;
    assign out_jump_o         = head.jump;
    assign out_illegal_o      = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one default instance (RV32, M on) and one
// RV64 instance without M, both driven by the same fetch-side stimulus.
module tb_decode_stage;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        out_ready_i;
    logic [31:0] in_instr_i;
    logic [31:0] in_pc_i;

    logic        a_in_ready, a_out_valid, a_muldiv, a_rd_we, a_mem_rd, a_mem_wr;
    logic        a_mem_unsigned, a_branch, a_jump, a_illegal;
    logic [31:0] a_pc, a_imm;
    logic [6:0]  a_opcode;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [3:0]  a_alu_op;
    logic [1:0]  a_mem_size;

    logic        b_in_ready, b_out_valid, b_muldiv, b_rd_we, b_mem_rd, b_mem_wr;
    logic        b_mem_unsigned, b_branch, b_jump, b_illegal;
    logic [31:0] b_pc;
    logic [63:0] b_imm;
    logic [6:0]  b_opcode;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [3:0]  b_alu_op;
    logic [1:0]  b_mem_size;

    int n_total = 0;
    int n_bad   = 0;

    decode_stage #(.XLEN(32), .PC_WIDTH(32), .SUPPORT_M(1)) u_a (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(a_in_ready),
        .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready_i),
        .out_pc_o(a_pc), .out_opcode_o(a_opcode),
        .out_rd_o(a_rd), .out_rs1_o(a_rs1), .out_rs2_o(a_rs2),
        .out_imm_o(a_imm), .out_alu_op_o(a_alu_op), .out_muldiv_o(a_muldiv),
        .out_rd_we_o(a_rd_we), .out_mem_rd_o(a_mem_rd), .out_mem_wr_o(a_mem_wr),
        .out_mem_size_o(a_mem_size), .out_mem_unsigned_o(a_mem_unsigned),
        .out_branch_o(a_branch), .out_jump_o(a_jump), .out_illegal_o(a_illegal)
    );

    decode_stage #(.XLEN(64), .PC_WIDTH(32), .SUPPORT_M(0)) u_b (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(b_in_ready),
        .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready_i),
        .out_pc_o(b_pc), .out_opcode_o(b_opcode),
        .out_rd_o(b_rd), .out_rs1_o(b_rs1), .out_rs2_o(b_rs2),
        .out_imm_o(b_imm), .out_alu_op_o(b_alu_op), .out_muldiv_o(b_muldiv),
        .out_rd_we_o(b_rd_we), .out_mem_rd_o(b_mem_rd), .out_mem_wr_o(b_mem_wr),
        .out_mem_size_o(b_mem_size), .out_mem_unsigned_o(b_mem_unsigned),
        .out_branch_o(b_branch), .out_jump_o(b_jump), .out_illegal_o(b_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        in_valid_i = 1'b1;
        in_instr_i = instr;
        in_pc_i    = pc;
        step();
        in_valid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        in_instr_i  = 32'h0;
        in_pc_i     = 32'h0;

        // reset held
        step(); step(); step();
        chk("rst_ready_low", a_in_ready, 0);
        chk("rst_valid", a_out_valid, 0);
        chk("rst_pc", a_pc, 0);
        chk("rst_imm", a_imm, 0);
        chk("rst_rd", a_rd, 0);
        rst_i = 1'b0;
        step();
        chk("post_rst_ready", a_in_ready, 1);
        chk("post_rst_valid", a_out_valid, 0);

        // addi x5,x0,-1
        issue(32'hFFF0_0293, 32'h100);
        chk("addi_valid", a_out_valid, 1);
        chk("addi_pc", a_pc, 32'h100);
        chk("addi_rd", a_rd, 5);
        chk("addi_rs1", a_rs1, 0);
        chk("addi_rs2", a_rs2, 0);
        chk("addi_imm", a_imm, 32'hFFFF_FFFF);
        chk("addi_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_alu", a_alu_op, 0);
        chk("addi_we", a_rd_we, 1);
        chk("addi_ill", a_illegal, 0);
        step();
        chk("addi_drained", a_out_valid, 0);

        // 8 back-to-back addi x(i+1),x0,i+1
        for (int i = 0; i < 8; i++) begin
            w = {12'(i + 1), 5'd0, 3'b000, 5'(i + 1), 7'b0010011};
            issue(w, 32'h200 + 32'(4 * i));
            chk("stream_valid", a_out_valid, 1);
            chk("stream_pc", a_pc, 32'h200 + 32'(4 * i));
            chk("stream_rd", a_rd, 64'(i + 1));
            chk("stream_imm", a_imm, 64'(i + 1));
            chk("stream_ready", a_in_ready, 1);
        end
        step();
        chk("stream_drained", a_out_valid, 0);

        // stall: offer A, B, C with out_ready low
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_instr_i  = 32'h0010_0093; in_pc_i = 32'h300;   // addi x1,x0,1
        step();
        chk("stall_a_head", a_pc, 32'h300);
        chk("stall_a_ready", a_in_ready, 1);
        in_instr_i  = 32'h0020_0113; in_pc_i = 32'h304;   // addi x2,x0,2
        step();
        chk("stall_b_ready", a_in_ready, 0);
        chk("stall_b_head", a_pc, 32'h300);
        in_instr_i  = 32'h0030_0193; in_pc_i = 32'h308;   // addi x3,x0,3
        step();
        chk("stall_c_held_ready", a_in_ready, 0);
        chk("stall_head_pc", a_pc, 32'h300);
        step();
        chk("stall_head_pc2", a_pc, 32'h300);
        chk("stall_head_rd2", a_rd, 1);
        chk("stall_valid", a_out_valid, 1);
        out_ready_i = 1'b1;
        step();
        chk("rel_b_pc", a_pc, 32'h304);
        chk("rel_b_rd", a_rd, 2);
        chk("rel_ready", a_in_ready, 1);
        step();
        in_valid_i = 1'b0;
        chk("rel_c_pc", a_pc, 32'h308);
        chk("rel_c_rd", a_rd, 3);
        step();
        chk("rel_drained", a_out_valid, 0);

        // flush while TWO with input offered
        out_ready_i = 1'b0;
        issue(32'h0040_0213, 32'h400);
        issue(32'h0050_0293, 32'h404);
        chk("fl_two_ready", a_in_ready, 0);
        in_valid_i = 1'b1; in_instr_i = 32'h0060_0313; in_pc_i = 32'h408;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        chk("fl_valid", a_out_valid, 0);
        chk("fl_ready", a_in_ready, 1);
        step();
        chk("fl_no_stale", a_out_valid, 0);
        // flush drops an input accepted in the same cycle
        in_valid_i = 1'b1; in_pc_i = 32'h40C;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("fl_drop_accept", a_out_valid, 0);
        issue(32'h0070_0393, 32'h410);
        chk("fl_after_pc", a_pc, 32'h410);
        chk("fl_after_rd", a_rd, 7);

        // reset mid-flight drops both entries
        out_ready_i = 1'b0;
        issue(32'h0010_0093, 32'h500);
        issue(32'h0020_0113, 32'h504);
        rst_i = 1'b1;
        step();
        chk("mrst_valid", a_out_valid, 0);
        chk("mrst_ready", a_in_ready, 0);
        chk("mrst_pc", a_pc, 0);
        rst_i = 1'b0; out_ready_i = 1'b1;
        step();
        chk("mrst_ready_back", a_in_ready, 1);
        chk("mrst_valid_after", a_out_valid, 0);

        // mul x1,x2,x3
        issue(32'h0231_00B3, 32'h600);
        chk("mul_muldiv", a_muldiv, 1);
        chk("mul_alu", a_alu_op, 0);
        chk("mul_we", a_rd_we, 1);
        chk("mul_ill", a_illegal, 0);
        chk("mul_rs2", a_rs2, 3);
        chk("mulnm_ill", b_illegal, 1);
        chk("mulnm_we", b_rd_we, 0);
        chk("mulnm_muldiv", b_muldiv, 0);

        // bge x1,x2,-4
        issue(32'hFE20_DEE3, 32'h604);
        chk("bge_branch", a_branch, 1);
        chk("bge_imm", a_imm, 32'hFFFF_FFFC);
        chk("bge_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("bge_alu", a_alu_op, 4'b0101);
        chk("bge_rs1", a_rs1, 1);
        chk("bge_rs2", a_rs2, 2);
        chk("bge_we", a_rd_we, 0);

        // unknown opcode
        issue(32'h0000_207F, 32'h608);
        chk("unk_ill", a_illegal, 1);
        chk("unk_we", a_rd_we, 0);
        chk("unk_opcode", a_opcode, 7'h7F);

        // lui x1,0x80000
        issue(32'h8000_00B7, 32'h60C);
        chk("lui_imm32", a_imm, 32'h8000_0000);
        chk("lui_imm64", b_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui_rd", a_rd, 1);
        chk("lui_we", a_rd_we, 1);
        chk("lui_rs1", a_rs1, 0);

        // srai x1,x1,31
        issue(32'h41F0_D093, 32'h610);
        chk("srai_alu", a_alu_op, 4'b1101);
        chk("srai_ill", a_illegal, 0);

        // slli x1,x1,32: only legal on RV64
        issue(32'h0200_9093, 32'h614);
        chk("slli32_ill", a_illegal, 1);
        chk("slli32_we", a_rd_we, 0);
        chk("slli64_ill", b_illegal, 0);

        // ld x1,0(x2): only legal on RV64
        issue(32'h0001_3083, 32'h618);
        chk("ld32_ill", a_illegal, 1);
        chk("ld32_memrd", a_mem_rd, 0);
        chk("ld64_memrd", b_mem_rd, 1);
        chk("ld64_size", b_mem_size, 2'b11);

        // lbu x1,0(x2)
        issue(32'h0001_4083, 32'h61C);
        chk("lbu_unsigned", a_mem_unsigned, 1);
        chk("lbu_size", a_mem_size, 0);

        // sw x3,8(x2)
        issue(32'h0031_2423, 32'h620);
        chk("sw_memwr", a_mem_wr, 1);
        chk("sw_imm", a_imm, 8);
        chk("sw_rd", a_rd, 0);

        // jalr x1,4(x2)
        issue(32'h0041_00E7, 32'h624);
        chk("jalr_jump", a_jump, 1);
        chk("jalr_imm", a_imm, 4);

        // ecall
        issue(32'h0000_0073, 32'h628);
        chk("ecall_ill", a_illegal, 0);
        chk("ecall_we", a_rd_we, 0);
        chk("ecall_jump", a_jump, 0);

        // sub x1,x2,x3 vs illegal 0100000 with funct3 001
        issue(32'h4031_00B3, 32'h62C);
        chk("sub_alu", a_alu_op, 4'b1000);
        chk("sub_ill", a_illegal, 0);
        issue(32'h4031_10B3, 32'h630);
        chk("bad_f7_ill", a_illegal, 1);

        // compressed-looking word
        issue(32'h0000_0001, 32'h634);
        chk("c_ill", a_illegal, 1);
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
